// File: rtl/nim_trig_pkg.sv
// Shared types for the NIM trigger stage: channel configuration, mode and FSM state encodings.
package nim_trig_pkg;

  localparam int NIM_N_IN       = 12;
  localparam int NIM_N_OUT      = 4;
  localparam int NIM_W_WIDTH    = 8;
  localparam int NIM_W_PRESCALE = 16;
  localparam int NIM_W_CNT      = 32;

  typedef enum logic [1:0] {
    MODE_OR  = 2'd0,
    MODE_AND = 2'd1,
    MODE_MAJ = 2'd2
  } trig_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DEAD  = 2'd2
  } trig_state_t;

  typedef struct packed {
    logic                      enable;
    trig_mode_t                mode;
    logic [NIM_N_IN-1:0]       mask;
    logic [NIM_N_IN-1:0]       veto_mask;
    logic [3:0]                threshold;
    logic [NIM_W_PRESCALE-1:0] prescale;
    logic [NIM_W_WIDTH-1:0]    width;
    logic [NIM_W_WIDTH-1:0]    deadtime;
  } chan_cfg_t;

  function automatic logic [3:0] popcount(input logic [NIM_N_IN-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NIM_N_IN; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/nim_trigger_logic_if.sv
// Trigger-stage bus: conditioned inputs, per-channel config/clear, output pulses and counters.
interface nim_trigger_logic_if
  import nim_trig_pkg::*;
#(
  parameter int N_IN  = NIM_N_IN,
  parameter int N_OUT = NIM_N_OUT,
  parameter int W_CNT = NIM_W_CNT
) ();

  logic [N_IN-1:0]              trig_in;
  chan_cfg_t [N_OUT-1:0]        cfg;
  logic [N_OUT-1:0]             count_clear;
  logic [N_OUT-1:0]             trig_out;
  logic [N_OUT-1:0][W_CNT-1:0]  raw_count;
  logic [N_OUT-1:0][W_CNT-1:0]  acc_count;

  modport master (
    output trig_in, cfg, count_clear,
    input  trig_out, raw_count, acc_count
  );

  modport slave (
    input  trig_in, cfg, count_clear,
    output trig_out, raw_count, acc_count
  );

endinterface

// File: rtl/nim_trig_channel.sv
// One output channel: coincidence, veto, edge detect, prescale, pulse/deadtime FSM, counters.
// Fire is registered one cycle after the registered inputs; trig_o is a flop output.
module nim_trig_channel
  import nim_trig_pkg::*;
#(
  parameter int N_IN       = NIM_N_IN,
  parameter int W_WIDTH    = NIM_W_WIDTH,
  parameter int W_PRESCALE = NIM_W_PRESCALE,
  parameter int W_CNT      = NIM_W_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  in_i,
  input  chan_cfg_t        cfg_i,
  input  logic             clear_i,
  output logic             trig_o,
  output logic [W_CNT-1:0] raw_count_o,
  output logic [W_CNT-1:0] acc_count_o
);

  trig_state_t           state_q, state_d;
  logic [W_WIDTH-1:0]    tmr_q, tmr_d;
  logic [W_WIDTH-1:0]    dead_q, dead_d;
  logic [W_PRESCALE-1:0] pc_q, pc_d;
  logic                  trig_q, trig_d;
  logic                  qual_prev_q, qual_prev_d;
  logic                  hold_q, hold_d;
  logic [W_CNT-1:0]      raw_q, raw_d;
  logic [W_CNT-1:0]      acc_q, acc_d;

  logic [N_IN-1:0]       sel;
  logic [3:0]            n_hit;
  logic                  cond, veto, qual, edge_det;
  logic [W_PRESCALE:0]   pc_inc, ps_eff;
  logic                  raw_inc, acc_inc;

  always_comb begin
    sel    = in_i & cfg_i.mask;
    n_hit  = popcount(sel);
    cond   = 1'b0;
    case (cfg_i.mode)
      MODE_OR:  cond = (n_hit != 4'd0);
      MODE_AND: cond = (cfg_i.mask != '0) && (sel == cfg_i.mask);
      MODE_MAJ: cond = (cfg_i.threshold != 4'd0) && (n_hit >= cfg_i.threshold);
      default:  cond = 1'b0;
    endcase
    veto     = |(in_i & cfg_i.veto_mask);
    qual     = cond & ~veto;
    // hold_q blocks a level that was already high when the channel was (re-)enabled
    edge_det = cfg_i.enable & qual & ~qual_prev_q & ~hold_q;
    pc_inc   = {1'b0, pc_q} + 1'b1;
    ps_eff   = (cfg_i.prescale == '0) ? {{W_PRESCALE{1'b0}}, 1'b1} : {1'b0, cfg_i.prescale};
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    dead_d      = dead_q;
    pc_d        = pc_q;
    trig_d      = trig_q;
    raw_inc     = 1'b0;
    acc_inc     = 1'b0;
    qual_prev_d = cfg_i.enable & qual;
    hold_d      = cfg_i.enable ? (hold_q & qual) : 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          raw_inc = 1'b1;
          if (pc_inc >= ps_eff) begin
            acc_inc = 1'b1;
            pc_d    = '0;
            tmr_d   = cfg_i.width;
            dead_d  = cfg_i.deadtime;
            trig_d  = 1'b1;
            state_d = ST_PULSE;
          end else begin
            pc_d = pc_inc[W_PRESCALE-1:0];
          end
        end
      end
      ST_PULSE: begin
        if (tmr_q == '0) begin
          trig_d = 1'b0;
          if (dead_q != '0) begin
            tmr_d   = dead_q;
            state_d = ST_DEAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_DEAD: begin
        if (tmr_q <= {{(W_WIDTH-1){1'b0}}, 1'b1}) state_d = ST_IDLE;
        else                                      tmr_d   = tmr_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        trig_d  = 1'b0;
      end
    endcase

    if (!cfg_i.enable) begin
      state_d = ST_IDLE;
      trig_d  = 1'b0;
      pc_d    = '0;
    end

    raw_d = raw_q;
    acc_d = acc_q;
    if (clear_i) begin
      raw_d = '0;
      acc_d = '0;
    end else begin
      if (raw_inc && (raw_q != '1)) raw_d = raw_q + 1'b1;
      if (acc_inc && (acc_q != '1)) acc_d = acc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      dead_q      <= '0;
      pc_q        <= '0;
      trig_q      <= 1'b0;
      qual_prev_q <= 1'b0;
      hold_q      <= 1'b1;
      raw_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      dead_q      <= dead_d;
      pc_q        <= pc_d;
      trig_q      <= trig_d;
      qual_prev_q <= qual_prev_d;
      hold_q      <= hold_d;
      raw_q       <= raw_d;
      acc_q       <= acc_d;
    end
  end

  assign trig_o      = trig_q;
  assign raw_count_o = raw_q;
  assign acc_count_o = acc_q;

endmodule

// File: rtl/nim_trigger_logic.sv
// NIM trigger stage: shared input register feeding N_OUT independent trigger channels.
// trig_out rises two cycles after a qualifying input change; no backpressure.
module nim_trigger_logic
  import nim_trig_pkg::*;
#(
  parameter int N_IN       = NIM_N_IN,
  parameter int N_OUT      = NIM_N_OUT,
  parameter int W_WIDTH    = NIM_W_WIDTH,
  parameter int W_PRESCALE = NIM_W_PRESCALE,
  parameter int W_CNT      = NIM_W_CNT
) (
  input  logic               clk,
  input  logic               reset,
  nim_trigger_logic_if.slave bus
);

  logic [N_IN-1:0] in_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_q <= '0;
    else       in_q <= bus.trig_in;
  end

  for (genvar c = 0; c < N_OUT; c++) begin : g_chan
    nim_trig_channel #(
      .N_IN       (N_IN),
      .W_WIDTH    (W_WIDTH),
      .W_PRESCALE (W_PRESCALE),
      .W_CNT      (W_CNT)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .in_i        (in_q),
      .cfg_i       (bus.cfg[c]),
      .clear_i     (bus.count_clear[c]),
      .trig_o      (bus.trig_out[c]),
      .raw_count_o (bus.raw_count[c]),
      .acc_count_o (bus.acc_count[c])
    );
  end

endmodule

// File: tb/tb_nim_trigger_logic.sv
// Bench for nim_trigger_logic: directed stimulus pushes expected pulses, a monitor pops and checks them.
module tb_nim_trigger_logic;
  import nim_trig_pkg::*;

  logic clk = 1'b0;
  logic reset;

  nim_trigger_logic_if #(.N_IN(12), .N_OUT(4), .W_CNT(32)) bus ();

  nim_trigger_logic #(
    .N_IN(12), .N_OUT(4), .W_WIDTH(8), .W_PRESCALE(16), .W_CNT(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int ch;
    int start;
    int len;
  } pulse_t;

  pulse_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input int start, input int len);
    pulse_t p;
    p.ch = ch; p.start = start; p.len = len;
    exp_q.push_back(p);
  endtask

  // Monitor: measure every completed pulse on every channel and pop its expectation.
  initial begin
    logic [3:0] prev_out;
    int         start_cyc [4];
    pulse_t     e;
    int         len;
    prev_out = '0;
    for (int c = 0; c < 4; c++) start_cyc[c] = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (bus.trig_out[c] && !prev_out[c]) start_cyc[c] = cyc;
        if (!bus.trig_out[c] && prev_out[c]) begin
          len = cyc - start_cyc[c];
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pulse_unexpected: got ch%0d start %0d len %0d, expected no pulse",
                     c, start_cyc[c], len);
          end else begin
            e = exp_q.pop_front();
            if (e.ch != c || e.start != start_cyc[c] || e.len != len) begin
              n_fail++;
              $display("FAIL pulse: got ch%0d start %0d len %0d, expected ch%0d start %0d len %0d",
                       c, start_cyc[c], len, e.ch, e.start, e.len);
            end
          end
        end
      end
      prev_out = bus.trig_out;
    end
  end

  function automatic chan_cfg_t mk_cfg(input trig_mode_t m, input logic [11:0] mask,
                                       input logic [11:0] veto, input logic [3:0] thr,
                                       input logic [15:0] ps, input logic [7:0] w,
                                       input logic [7:0] dt);
    chan_cfg_t c;
    c.enable = 1'b1; c.mode = m; c.mask = mask; c.veto_mask = veto;
    c.threshold = thr; c.prescale = ps; c.width = w; c.deadtime = dt;
    return c;
  endfunction

  task automatic set_cfg(input int ch, input chan_cfg_t c);
    @(negedge clk); bus.cfg[ch].enable = 1'b0;
    @(negedge clk); bus.cfg[ch] = c;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_cnt(input int ch);
    @(negedge clk); bus.count_clear[ch] = 1'b1;
    @(negedge clk); bus.count_clear[ch] = 1'b0;
  endtask

  task automatic drive(input logic [11:0] v);
    @(negedge clk); bus.trig_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_counts(input string name, input logic [31:0] raw, input logic [31:0] acc);
    chk({name, "_raw"}, bus.raw_count[0], raw);
    chk({name, "_acc"}, bus.acc_count[0], acc);
  endtask

  initial begin
    int s;
    reset           = 1'b1;
    bus.trig_in     = '0;
    bus.cfg         = '0;
    bus.count_clear = '0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rst_trig%0d", c), bus.trig_out[c], 0);
      chk($sformatf("rst_raw%0d", c), bus.raw_count[c], 0);
      chk($sformatf("rst_acc%0d", c), bus.acc_count[c], 0);
    end
    reset = 1'b0;
    idle(2);

    // OR, single-cycle input pulse -> 5-cycle output two cycles later
    set_cfg(0, mk_cfg(MODE_OR, 12'h003, 12'h000, 4'd0, 16'd1, 8'd4, 8'd0));
    clear_cnt(0);
    drive(12'h002); push(0, cyc + 2, 5);
    drive(12'h000);
    idle(10);
    chk_counts("or", 1, 1);

    // AND: partial coincidence silent, full coincidence fires once even if held
    set_cfg(0, mk_cfg(MODE_AND, 12'h00F, 12'h000, 4'd0, 16'd1, 8'd0, 8'd0));
    clear_cnt(0);
    drive(12'h007);
    idle(6);
    drive(12'h00F); push(0, cyc + 2, 1);
    idle(100);
    drive(12'h000);
    idle(4);
    chk_counts("and", 1, 1);

    // Majority of 3 with veto on input 11
    set_cfg(0, mk_cfg(MODE_MAJ, 12'hFFF, 12'h800, 4'd3, 16'd1, 8'd1, 8'd0));
    clear_cnt(0);
    drive(12'h007); push(0, cyc + 2, 2);
    drive(12'h000);
    idle(6);
    chk_counts("maj", 1, 1);
    drive(12'h807);
    idle(4);
    drive(12'h000);
    idle(6);
    chk_counts("veto", 1, 1);

    // Prescale 4: ten edges, pulses on the 4th and 8th
    set_cfg(0, mk_cfg(MODE_OR, 12'h001, 12'h000, 4'd0, 16'd4, 8'd0, 8'd0));
    clear_cnt(0);
    for (int i = 1; i <= 10; i++) begin
      drive(12'h001);
      if (i % 4 == 0) push(0, cyc + 2, 1);
      drive(12'h000);
      idle(2);
    end
    idle(3);
    chk_counts("prescale", 10, 2);

    // Deadtime: edge at fire+3 ignored, edge at fire+8 (first IDLE cycle) accepted
    set_cfg(0, mk_cfg(MODE_OR, 12'h001, 12'h000, 4'd0, 16'd1, 8'd2, 8'd5));
    clear_cnt(0);
    for (int k = 0; k < 16; k++) begin
      drive((k == 0 || k == 4 || k == 9) ? 12'h001 : 12'h000);
      if (k == 0 || k == 9) push(0, cyc + 2, 3);
    end
    idle(4);
    chk_counts("dead", 2, 2);

    // Saturation at all-ones, then clear colliding with an increment
    set_cfg(0, mk_cfg(MODE_OR, 12'h001, 12'h000, 4'd0, 16'd1, 8'd0, 8'd0));
    force dut.g_chan[0].u_chan.raw_q = 32'hFFFF_FFFF;
    force dut.g_chan[0].u_chan.acc_q = 32'hFFFF_FFFF;
    idle(2);
    release dut.g_chan[0].u_chan.raw_q;
    release dut.g_chan[0].u_chan.acc_q;
    drive(12'h001); push(0, cyc + 2, 1);
    drive(12'h000);
    idle(4);
    chk_counts("sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive(12'h001); push(0, cyc + 2, 1);
    @(negedge clk); bus.trig_in = 12'h000; bus.count_clear[0] = 1'b1;
    @(negedge clk); bus.count_clear[0] = 1'b0;
    idle(3);
    chk_counts("clr_win", 0, 0);

    // Re-enable with input already high must not fire until it falls and rises
    set_cfg(0, mk_cfg(MODE_OR, 12'h001, 12'h000, 4'd0, 16'd1, 8'd0, 8'd0));
    clear_cnt(0);
    @(negedge clk); bus.cfg[0].enable = 1'b0;
    drive(12'h001);
    idle(2);
    @(negedge clk); bus.cfg[0].enable = 1'b1;
    idle(5);
    drive(12'h000);
    idle(2);
    drive(12'h001); push(0, cyc + 2, 1);
    drive(12'h000);
    idle(4);
    chk_counts("reen", 1, 1);

    // Reset mid-pulse drops trig_out asynchronously
    set_cfg(0, mk_cfg(MODE_OR, 12'h001, 12'h000, 4'd0, 16'd1, 8'd20, 8'd0));
    drive(12'h001); s = cyc + 2; push(0, s, 4);
    drive(12'h000);
    while (cyc < s + 3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_async_trig", bus.trig_out[0], 0);
    @(negedge clk);
    chk_counts("rst_mid", 0, 0);
    idle(2);
    reset = 1'b0;
    idle(5);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
